// File: rtl/imem_responder.sv
// Instruction memory with a streaming program-load port and a 1-cycle registered fetch read.
// Optional RELOAD input (return from RUN to LOAD without clearing memory) when IMEM_RELOAD_EN is defined.
module imem_responder #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0040_0000
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        LOAD_VALID,
    input  logic [31:0] LOAD_DATA,
    input  logic        LOAD_LAST,
    output logic        LOAD_READY,
    output logic        LOAD_OVF,
    output logic        FSM_SEL,
    input  logic        RD_EN,
    input  logic [31:0] PC_ADDR,
    output logic [31:0] INSTR_MEM_DOUT,
`ifdef IMEM_RELOAD_EN
    input  logic        RELOAD,
`endif
    output logic        ADDR_FAULT
);

    localparam int unsigned   AW       = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [31:0]   SPAN     = 32'(DEPTH * 4);

    typedef enum logic {
        S_LOAD,
        S_RUN
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [AW-1:0] r_ptr;
    logic          r_ovf;
    logic [31:0]   r_mem [DEPTH];
    logic [31:0]   r_dout;
    logic          r_fault;

    logic          w_accept;
    logic          w_ovf_word;
    logic          w_reload;
    logic [31:0]   w_offset;
    logic [AW-1:0] w_idx;
    logic          w_fault;

`ifdef IMEM_RELOAD_EN
    assign w_reload = RELOAD;
`else
    assign w_reload = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        FSM_SEL      = 1'b1;
        LOAD_READY   = 1'b1;
        w_accept     = 1'b0;
        w_ovf_word   = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_accept   = LOAD_VALID;
                w_ovf_word = LOAD_VALID && !LOAD_LAST && (r_ptr == LAST_PTR);
                if (LOAD_VALID && (LOAD_LAST || (r_ptr == LAST_PTR))) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                FSM_SEL    = 1'b0;
                LOAD_READY = 1'b0;
                if (w_reload) begin
                    w_next_state = S_LOAD;
                end
            end
            default: w_next_state = S_LOAD;
        endcase
    end

    // Pointer saturates at the last word so an overflowing stream never wraps onto word 0.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_ptr <= '0;
            r_ovf <= 1'b0;
        end else if ((r_state == S_RUN) && w_reload) begin
            r_ptr <= '0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            if (r_ptr != LAST_PTR) begin
                r_ptr <= r_ptr + 1'b1;
            end
            if (w_ovf_word) begin
                r_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_accept) begin
            r_mem[r_ptr] <= LOAD_DATA;
        end
    end

    // Offset is checked rather than PC against BASE_ADDR+SPAN so a base near the top of the map cannot overflow.
    assign w_offset = PC_ADDR - BASE_ADDR;
    assign w_idx    = w_offset[AW+1:2];
    assign w_fault  = (PC_ADDR[1:0] != 2'b00) || (PC_ADDR < BASE_ADDR) || (w_offset >= SPAN);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_dout  <= '0;
            r_fault <= 1'b0;
        end else if (r_state == S_LOAD) begin
            r_dout  <= '0;
            r_fault <= 1'b0;
        end else if (RD_EN) begin
            if (w_fault) begin
                r_dout  <= '0;
                r_fault <= 1'b1;
            end else begin
                r_dout  <= r_mem[w_idx];
                r_fault <= 1'b0;
            end
        end
    end

    assign LOAD_OVF       = r_ovf;
    assign INSTR_MEM_DOUT = r_dout;
    assign ADDR_FAULT     = r_fault;

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed program/fetch scenarios plus a randomized
// load-and-fetch phase, all compared against a word-array reference model.
module tb_imem_responder;

    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0040_0000;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b1;
    logic        LOAD_VALID = 1'b0;
    logic [31:0] LOAD_DATA = '0;
    logic        LOAD_LAST = 1'b0;
    logic        LOAD_READY;
    logic        LOAD_OVF;
    logic        FSM_SEL;
    logic        RD_EN = 1'b0;
    logic [31:0] PC_ADDR = '0;
    logic [31:0] INSTR_MEM_DOUT;
    logic        ADDR_FAULT;
`ifdef IMEM_RELOAD_EN
    logic        RELOAD = 1'b0;
`endif

    imem_responder #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE)
    ) dut (
        .CLK            (CLK),
        .RSTn           (RSTn),
        .LOAD_VALID     (LOAD_VALID),
        .LOAD_DATA      (LOAD_DATA),
        .LOAD_LAST      (LOAD_LAST),
        .LOAD_READY     (LOAD_READY),
        .LOAD_OVF       (LOAD_OVF),
        .FSM_SEL        (FSM_SEL),
        .RD_EN          (RD_EN),
        .PC_ADDR        (PC_ADDR),
        .INSTR_MEM_DOUT (INSTR_MEM_DOUT),
`ifdef IMEM_RELOAD_EN
        .RELOAD         (RELOAD),
`endif
        .ADDR_FAULT     (ADDR_FAULT)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: program image, load/run mode, pointer, sticky overflow, last response.
    logic [31:0] m_mem [DEPTH];
    bit          m_load;
    int unsigned m_ptr;
    bit          m_ovf;
    logic [31:0] m_dout;
    bit          m_fault;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".dout"},  INSTR_MEM_DOUT, m_dout);
        chk({tag, ".fault"}, {31'b0, ADDR_FAULT}, {31'b0, m_fault});
        chk({tag, ".fsm"},   {31'b0, FSM_SEL},    {31'b0, m_load});
        chk({tag, ".ready"}, {31'b0, LOAD_READY}, {31'b0, m_load});
        chk({tag, ".ovf"},   {31'b0, LOAD_OVF},   {31'b0, m_ovf});
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_load  = 1'b1;
        m_ptr   = 0;
        m_ovf   = 1'b0;
        m_dout  = '0;
        m_fault = 1'b0;
    endtask

    task automatic model_cycle(input bit v, input logic [31:0] d, input bit l,
                               input bit rd, input logic [31:0] pc);
        longint unsigned p;
        longint unsigned lo;
        p  = pc;
        lo = BASE;
        if (m_load) begin
            m_dout  = '0;
            m_fault = 1'b0;
            if (v) begin
                m_mem[m_ptr] = d;
                if (l) m_load = 1'b0;
                else if (m_ptr == DEPTH - 1) begin
                    m_ovf  = 1'b1;
                    m_load = 1'b0;
                end else m_ptr++;
            end
        end else if (rd) begin
            if ((p % 4 != 0) || (p < lo) || (p >= lo + 4 * DEPTH)) begin
                m_dout  = '0;
                m_fault = 1'b1;
            end else begin
                m_dout  = m_mem[(p - lo) / 4];
                m_fault = 1'b0;
            end
        end
    endtask

    task automatic step(input string tag, input bit v, input logic [31:0] d, input bit l,
                        input bit rd, input logic [31:0] pc);
        LOAD_VALID = v;
        LOAD_DATA  = d;
        LOAD_LAST  = l;
        RD_EN      = rd;
        PC_ADDR    = pc;
        model_cycle(v, d, l, rd, pc);
        @(posedge CLK);
        #1;
        chk_all(tag);
    endtask

    task automatic do_reset();
        LOAD_VALID = 1'b0;
        LOAD_LAST  = 1'b0;
        RD_EN      = 1'b0;
        RSTn       = 1'b0;
        model_reset();
        #2;
        chk_all("rst_async");
        @(posedge CLK);
        #1;
        chk_all("rst_held");
        RSTn = 1'b1;
    endtask

    function automatic logic [31:0] rand_pc();
        case ($urandom_range(0, 5))
            0:       return BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
            1:       return BASE - 32'(4 * $urandom_range(1, 4));
            2:       return BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
            default: return BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
        endcase
    endfunction

    initial begin
        #1;
        do_reset();

        // Three-word program and sequential fetch.
        step("ld0", 1, 32'h0050_0093, 0, 0, '0);
        step("ld1", 1, 32'h0010_0113, 0, 1, BASE);
        step("ld2", 1, 32'h0020_81B3, 1, 0, '0);
        step("run_idle", 1, 32'hDEAD_BEEF, 0, 0, BASE);
        step("fetch0", 0, '0, 0, 1, 32'h0040_0000);
        step("fetch1", 0, '0, 0, 1, 32'h0040_0004);
        step("fetch2", 0, '0, 0, 1, 32'h0040_0008);
        step("unwritten", 0, '0, 0, 1, 32'h0040_000C);

        // Misaligned, below-base and past-end faults, then recovery.
        step("misalign", 0, '0, 0, 1, 32'h0040_0002);
        step("recover", 0, '0, 0, 1, 32'h0040_0008);
        step("below", 0, '0, 0, 1, 32'h003F_FFFC);
        step("past_end", 0, '0, 0, 1, BASE + 32'(4 * DEPTH));
        step("last_word", 0, '0, 0, 1, BASE + 32'(4 * (DEPTH - 1)));

        // Stall holds the response while PC moves.
        step("pre_stall", 0, '0, 0, 1, 32'h0040_0004);
        step("stall0", 0, '0, 0, 0, 32'h0040_0000);
        step("stall1", 0, '0, 0, 0, 32'h0040_0002);
        step("stall2", 0, '0, 0, 0, 32'h0040_0008);

        // Reset mid-load discards the partial program.
        do_reset();
        step("ml0", 1, 32'h1111_1111, 0, 0, '0);
        step("ml1", 1, 32'h2222_2222, 0, 0, '0);
        do_reset();
        step("ml_new", 1, 32'h3333_3333, 1, 0, '0);
        step("ml_rd0", 0, '0, 0, 1, 32'h0040_0000);
        step("ml_rd1", 0, '0, 0, 1, 32'h0040_0004);

        // Overflow: DEPTH words with no LAST.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            step("ovf_ld", 1, $urandom, 0, 1, BASE);
        end
        step("ovf_ignore", 1, 32'hFFFF_FFFF, 1, 1, BASE + 32'(4 * (DEPTH - 1)));
        step("ovf_rd0", 0, '0, 0, 1, BASE);

        // Randomized program lengths and fetch streams.
        for (int t = 0; t < 6; t++) begin
            int unsigned n;
            int unsigned acc;
            do_reset();
            n   = (t == 0) ? DEPTH : $urandom_range(1, DEPTH);
            acc = 0;
            while (acc < n) begin
                bit v;
                v = ($urandom_range(0, 3) != 0);
                step("rnd_ld", v, $urandom, v && (acc + 1 == n), $urandom_range(0, 1), rand_pc());
                if (v) acc++;
            end
            for (int k = 0; k < 30; k++) begin
                step("rnd_rd", $urandom_range(0, 1), $urandom, 0, ($urandom_range(0, 3) != 0), rand_pc());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
